// File: rtl/poci_gpio_in.sv
// Debounced GPIO input block with POCI register access and edge interrupts.
// Each channel: 2-flop synchronizer, then a saturating-run debounce filter, then rise/fall edge flags.
module poci_gpio_in #(
  parameter int               WIDTH           = 14,
  parameter int               DEBOUNCE_CYCLES = 20000,
  parameter logic [WIDTH-1:0] IDLE_LEVEL      = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       paddr,
  input  logic             pwrite,
  input  logic             psel,
  input  logic             penable,
  input  logic [31:0]      pwdata,
  output logic [31:0]      prdata,
  output logic             pready,
  output logic             pslverr,
  input  logic [WIDTH-1:0] gpio_in,
  output logic             irq
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_stable;
  logic [WIDTH-1:0] w_stable_next;
  logic [WIDTH-1:0] r_rise_en;
  logic [WIDTH-1:0] r_fall_en;
  logic [WIDTH-1:0] r_pend;
  logic [WIDTH-1:0] w_pend_next;
  logic [WIDTH-1:0] w_set;
  logic [WIDTH-1:0] w_clr;
  logic [WIDTH-1:0] w_wdata;
  logic             w_access;
  logic             w_wr;
  logic [1:0]       w_sel;
  logic             w_unused_bits;

  assign w_access      = psel & penable;
  assign w_wr          = w_access & pwrite;
  assign w_sel         = paddr[3:2];
  assign w_wdata       = pwdata[WIDTH-1:0];
  assign w_unused_bits = ^{paddr[1:0], pwdata};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= IDLE_LEVEL;
      r_sync2 <= IDLE_LEVEL;
    end else begin
      r_sync1 <= gpio_in;
      r_sync2 <= r_sync1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : gen_ch
      logic [CW-1:0] r_cnt;
      logic          w_diff;

      assign w_diff            = r_sync2[gi] != r_stable[gi];
      // The mismatch must survive DEBOUNCE_CYCLES consecutive samples before it is accepted.
      assign w_stable_next[gi] = (w_diff && (r_cnt == CNT_LAST)) ? r_sync2[gi] : r_stable[gi];

      always_ff @(posedge clk) begin
        if (reset || !w_diff || (r_cnt == CNT_LAST)) begin
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stable <= IDLE_LEVEL;
    end else begin
      r_stable <= w_stable_next;
    end
  end

  assign w_set       = (r_rise_en & ~r_stable & w_stable_next) |
                       (r_fall_en & r_stable & ~w_stable_next);
  assign w_clr       = (w_wr && (w_sel == 2'd3)) ? w_wdata : '0;
  // A new edge outranks a simultaneous write-one-to-clear.
  assign w_pend_next = (r_pend & ~w_clr) | w_set;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rise_en <= '0;
      r_fall_en <= '0;
      r_pend    <= '0;
    end else begin
      if (w_wr && (w_sel == 2'd1)) r_rise_en <= w_wdata;
      if (w_wr && (w_sel == 2'd2)) r_fall_en <= w_wdata;
      r_pend <= w_pend_next;
    end
  end

  always_comb begin
    prdata = '0;
    if (w_access && !reset) begin
      case (w_sel)
        2'd0:    prdata[WIDTH-1:0] = r_stable;
        2'd1:    prdata[WIDTH-1:0] = r_rise_en;
        2'd2:    prdata[WIDTH-1:0] = r_fall_en;
        default: prdata[WIDTH-1:0] = r_pend;
      endcase
    end
  end

  assign pready  = 1'b1;
  assign pslverr = !reset && w_wr && (w_sel == 2'd0);
  assign irq     = !reset && (|r_pend);

endmodule

// File: tb/tb_poci_gpio_in.sv
// Bench for poci_gpio_in: directed scenarios with literal expectations plus randomized traffic
// checked every cycle against a window-based behavioural model.
module tb_poci_gpio_in;

  localparam int         DC   = 4;
  localparam logic [3:0] IDLE = 4'h0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  paddr = '0;
  logic        pwrite = 1'b0;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic [31:0] pwdata = '0;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic [3:0]  gpio_in = '0;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  poci_gpio_in #(
    .WIDTH(4),
    .DEBOUNCE_CYCLES(DC),
    .IDLE_LEVEL(IDLE)
  ) dut (
    .clk(clk),
    .reset(reset),
    .paddr(paddr),
    .pwrite(pwrite),
    .psel(psel),
    .penable(penable),
    .pwdata(pwdata),
    .prdata(prdata),
    .pready(pready),
    .pslverr(pslverr),
    .gpio_in(gpio_in),
    .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: stable flips once the last DC synchronized samples all disagree with it.
  logic [3:0] m_stable, m_pend, m_rise, m_fall;
  logic [3:0] m_raw_q[$];
  logic [3:0] m_win[$];
  bit         m_started = 0;

  always @(posedge clk) begin : model
    logic [3:0] s, nxt, set, clr;
    bit all_diff;
    if (reset) begin
      m_stable = IDLE; m_pend = '0; m_rise = '0; m_fall = '0;
      m_raw_q.delete(); m_raw_q.push_back(IDLE); m_raw_q.push_back(IDLE);
      m_win.delete();
      for (int k = 0; k < DC; k++) m_win.push_back(IDLE);
      m_started = 1;
    end else if (m_started) begin
      s = m_raw_q.pop_front();
      m_raw_q.push_back(gpio_in);
      void'(m_win.pop_front());
      m_win.push_back(s);
      nxt = m_stable;
      for (int i = 0; i < 4; i++) begin
        all_diff = 1;
        foreach (m_win[k]) if (m_win[k][i] == m_stable[i]) all_diff = 0;
        if (all_diff) nxt[i] = ~m_stable[i];
      end
      set = (m_rise & ~m_stable & nxt) | (m_fall & m_stable & ~nxt);
      clr = '0;
      if (psel && penable && pwrite) begin
        case (paddr[3:2])
          2'd1: m_rise = pwdata[3:0];
          2'd2: m_fall = pwdata[3:0];
          2'd3: clr = pwdata[3:0];
          default: ;
        endcase
      end
      m_pend   = (m_pend & ~clr) | set;
      m_stable = nxt;
    end
  end

  always @(negedge clk) begin : compare
    logic [31:0] e_rd;
    if (m_started) begin
      e_rd = '0;
      if (!reset && psel && penable) begin
        case (paddr[3:2])
          2'd0: e_rd = {28'b0, m_stable};
          2'd1: e_rd = {28'b0, m_rise};
          2'd2: e_rd = {28'b0, m_fall};
          default: e_rd = {28'b0, m_pend};
        endcase
      end
      chk("model_prdata", prdata, e_rd);
      chk("model_pslverr", {31'b0, pslverr}, {31'b0, !reset && psel && penable && pwrite && paddr[3:2] == 2'd0});
      chk("model_irq", {31'b0, irq}, {31'b0, !reset && (|m_pend)});
      chk("model_pready", {31'b0, pready}, 32'd1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d, output logic e);
    psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = a;
    #1;
    d = prdata; e = pslverr;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] v, output logic e);
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = a; pwdata = v;
    #1;
    e = pslverr;
    tick();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  initial begin : stim
    logic [31:0] d;
    logic        e;
    int          toggle_div;

    // Reset state
    tick(); tick();
    rd(4'h0, d, e);
    chk("reset_prdata", d, 32'h0);
    chk("reset_pready", {31'b0, pready}, 32'd1);
    chk("reset_irq", {31'b0, irq}, 32'd0);
    tick();
    reset = 1'b0;
    tick(); tick();

    // Debounce latency: visible on exactly the 6th edge
    gpio_in = 4'b0001;
    for (int k = 1; k <= 6; k++) begin
      tick();
      rd(4'h0, d, e);
      chk($sformatf("latency_edge%0d", k), d, (k == 6) ? 32'h1 : 32'h0);
    end

    // Glitch of 3 synchronized cycles is discarded
    gpio_in = 4'b0011;
    tick(); tick(); tick();
    gpio_in = 4'b0001;
    repeat (8) tick();
    rd(4'h0, d, e); chk("glitch_data", d, 32'h1);
    rd(4'hC, d, e); chk("glitch_pending", d, 32'h0);
    chk("glitch_irq", {31'b0, irq}, 32'd0);

    // Rise interrupt and W1C clear
    wr(4'h4, 32'h4, e);
    chk("rise_en_wr_err", {31'b0, e}, 32'd0);
    gpio_in = 4'b0101;
    repeat (6) tick();
    rd(4'hC, d, e); chk("rise_pending", d, 32'h4);
    chk("rise_irq", {31'b0, irq}, 32'd1);
    wr(4'hC, 32'h4, e);
    rd(4'hC, d, e); chk("w1c_pending", d, 32'h0);
    chk("w1c_irq", {31'b0, irq}, 32'd0);

    // Set/clear collision on PENDING[3]
    wr(4'h8, 32'h8, e);
    gpio_in = 4'b1101;
    repeat (6) tick();
    rd(4'h0, d, e); chk("bit3_high_data", d, 32'hD);
    rd(4'hC, d, e); chk("bit3_rise_masked", d, 32'h0);
    gpio_in = 4'b0101;
    repeat (5) tick();
    wr(4'hC, 32'h8, e);
    rd(4'hC, d, e); chk("collision_pending", d, 32'h8);
    chk("collision_irq", {31'b0, irq}, 32'd1);
    rd(4'h0, d, e); chk("collision_data", d, 32'h5);

    // Bus error on DATA write
    wr(4'h0, 32'hFFFF_FFFF, e);
    chk("data_wr_pslverr", {31'b0, e}, 32'd1);
    rd(4'h0, d, e); chk("data_unchanged", d, 32'h5);
    rd(4'h8, d, e);
    chk("fall_en_read", d, 32'h8);
    chk("fall_en_read_err", {31'b0, e}, 32'd0);
    wr(4'hC, 32'hFFFF_FFF8, e);
    chk("w1c_err", {31'b0, e}, 32'd0);
    rd(4'hC, d, e); chk("upper_bits_ignored", d, 32'h0);

    // Reset mid-count
    wr(4'h4, 32'hF, e);
    wr(4'h8, 32'hF, e);
    gpio_in = 4'b0110;
    tick(); tick();
    reset = 1'b1;
    rd(4'h0, d, e); chk("in_reset_prdata", d, 32'h0);
    tick();
    reset = 1'b0;
    rd(4'h0, d, e); chk("post_reset_data", d, 32'h0);
    rd(4'hC, d, e); chk("post_reset_pending", d, 32'h0);
    repeat (5) tick();
    rd(4'h0, d, e); chk("restart_edge5", d, 32'h0);
    tick();
    rd(4'h0, d, e); chk("restart_edge6", d, 32'h6);
    rd(4'hC, d, e); chk("restart_no_pending", d, 32'h0);

    // Randomized traffic, checked every cycle by the compare process
    toggle_div = 3;
    for (int c = 0; c < 4000; c++) begin
      tick();
      if (c % 250 == 0) toggle_div = $urandom_range(2, 14);
      reset = ($urandom_range(0, 699) == 0);
      if ($urandom_range(0, toggle_div - 1) == 0) gpio_in = gpio_in ^ 4'($urandom);
      psel    = $urandom_range(0, 1) == 1;
      penable = psel && ($urandom_range(0, 2) != 0);
      pwrite  = $urandom_range(0, 1) == 1;
      paddr   = 4'($urandom);
      pwdata  = $urandom;
    end
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; reset = 1'b0;
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/poci_gpio_in.md
POCI_GPIO_IN -- requirements
Module: poci_gpio_in

Interface
REQ-001 SHALL have parameter WIDTH, default 14, number of input channels, legal range 1..32.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 20000 (1 ms at 20 MHz), legal minimum 2.
REQ-003 SHALL have parameter IDLE_LEVEL, default all zeros, WIDTH bits, per-channel reset level.
REQ-004 SHALL have port clk, input, 1 bit, the single clock of the block.
REQ-005 SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-006 SHALL have port paddr, input, 4 bits, POCI byte address; bits [1:0] are ignored.
REQ-007 SHALL have ports pwrite, psel and penable, input, 1 bit each, POCI control.
REQ-008 SHALL have port pwdata, input, 32 bits, POCI write data.
REQ-009 SHALL have port prdata, output, 32 bits, POCI read data.
REQ-010 SHALL have ports pready and pslverr, output, 1 bit each, POCI completion and error.
REQ-011 SHALL have port gpio_in, input, WIDTH bits, asynchronous raw inputs (keys, switches).
REQ-012 SHALL have port irq, output, 1 bit, level interrupt request.

Function
REQ-013 SHALL pass each gpio_in bit through a 2-flop synchronizer before any other use.
REQ-014 SHALL keep, per channel, a debounced value `stable` and a counter of width clog2(DEBOUNCE_CYCLES).
- sync == stable: counter cleared.
- sync != stable: counter increments.
- Counter at DEBOUNCE_CYCLES-1 with sync still != stable: stable takes sync on that edge and the counter clears.
REQ-015 SHALL give a latency of 2+DEBOUNCE_CYCLES clk edges from a steady input change to the stable change.
REQ-016 SHALL discard any glitch shorter than DEBOUNCE_CYCLES synchronized cycles; stable is unchanged and no edge is flagged.
REQ-017 SHALL implement this register map (address, access, content):
- 0x0, RO: DATA = stable.
- 0x4, RW: RISE_EN.
- 0x8, RW: FALL_EN.
- 0xC, W1C: PENDING.
Unused upper bits read 0.
REQ-018 SHALL set PENDING[i] on the same edge stable[i] changes 0->1 when RISE_EN[i]=1, or 1->0 when FALL_EN[i]=1.
REQ-019 SHALL let the set win when a set and a W1C clear of the same PENDING bit occur on the same edge.
REQ-020 SHALL drive irq = OR of PENDING, combinational from the PENDING flops.
REQ-021 SHALL treat psel&penable as the access cycle, with pready=1 and no wait states.
REQ-022 SHALL drive prdata as the addressed register in the access cycle and 0 otherwise.
REQ-023 SHALL perform register writes on the access-cycle edge.
REQ-024 SHALL assert pslverr for one access cycle on a write to 0x0; the write has no effect.
REQ-025 SHALL keep pslverr low in all other cases, including reads and writes of 0x4, 0x8 and 0xC.
REQ-026 SHALL ignore pwdata bits at and above WIDTH.
REQ-027 SHALL have no effect on enable writes for edges already pending; the enables mask only future edges.

Reset
REQ-028 SHALL, on reset, load IDLE_LEVEL into the synchronizer flops and stable.
REQ-029 SHALL, on reset, clear all counters, RISE_EN, FALL_EN and PENDING.
REQ-030 SHALL hold prdata=0, pslverr=0 and irq=0 during reset, with pready=1.
REQ-031 SHALL abort in-progress debounce counts when reset is asserted mid-count, with no edge flagged.
REQ-032 SHALL restart filtering cleanly after reset; a channel whose input differs from IDLE_LEVEL updates stable after 2+DEBOUNCE_CYCLES edges without setting PENDING, since the enables are 0.

Verification (WIDTH=4, DEBOUNCE_CYCLES=4, IDLE_LEVEL=0)
REQ-033 SHALL cover debounce latency: reset, then gpio_in=0001 held -> DATA reads 0x1 exactly 6 edges later and 0x0 before that.
REQ-034 SHALL cover glitch rejection: gpio_in[1] high for 3 synchronized cycles, then low -> DATA stays 0x0, PENDING stays 0x0, irq=0.
REQ-035 SHALL cover rise interrupt and W1C clear: write RISE_EN=0x4, raise gpio_in[2] -> PENDING=0x4 and irq=1 after debounce; write 0xC with 0x4 -> PENDING=0x0, irq=0.
REQ-036 SHALL cover set/clear collision: W1C of PENDING[3] lands on the same edge stable[3] falls with FALL_EN[3]=1 -> PENDING[3]=1 after that edge.
REQ-037 SHALL cover the bus error: write 0x0 -> pslverr=1 in the access cycle, DATA unchanged; read of 0x8 -> pslverr=0 and FALL_EN value returned.
REQ-038 SHALL cover reset mid-count: input toggled, reset pulsed 2 edges later -> DATA=0, PENDING=0; after release DATA follows the held input after 6 edges.
